// File: rtl/eqn_reduce_qual.sv
// Purpose : reduce in_i with OR/AND/XOR and qualify it over QUAL_CYC cycles; stretch the result by HOLD_CYC or latch it (sticky).
// Latency : yo rises on the edge that takes the QUAL_CYC-th consecutive true sample; rise_o/fall_o rise on the same edge as the yo change.
// Backpressure: none; the block samples its inputs every cycle and cannot stall.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_ni   - asynchronous active-low reset
//   en_i     - enable; 0 forces the condition false
//   clr_i    - synchronous clear; overrides everything except reset
//   sticky_i - when 1, yo stays latched in ACTIVE until clr_i
//   in_i     - input vector, synchronous to clk_i
//   yo       - qualified, stretched condition (registered)
//   rise_o   - one-cycle pulse on the cycle yo goes 0->1 (registered)
//   fall_o   - one-cycle pulse on the cycle yo goes 1->0 (registered)
module eqn_reduce_qual #(
  parameter int N_IN     = 2,
  parameter int MODE     = 0,
  parameter int QUAL_CYC = 1,
  parameter int HOLD_CYC = 0,
  parameter int CNT_W    = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            sticky_i,
  input  logic [N_IN-1:0] in_i,
  output logic            yo,
  output logic            rise_o,
  output logic            fall_o
);

  // Parameter legality checks, resolved at elaboration.
  if (N_IN < 1) begin : g_bad_n_in
    $error("eqn_reduce_qual: N_IN must be >= 1");
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("eqn_reduce_qual: MODE must be 0 (OR), 1 (AND) or 2 (XOR)");
  end
  if (QUAL_CYC < 1 || QUAL_CYC > (1 << CNT_W) - 1) begin : g_bad_qual
    $error("eqn_reduce_qual: QUAL_CYC out of range for CNT_W");
  end
  if (HOLD_CYC < 0 || HOLD_CYC > (1 << CNT_W) - 1) begin : g_bad_hold
    $error("eqn_reduce_qual: HOLD_CYC out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(QUAL_CYC - 1);
  // HOLD is entered on the first false sample, so that sample already
  // accounts for one of the HOLD_CYC stretched cycles.
  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_QUAL   = 2'd1,
    S_ACTIVE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] qcnt_q, qcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             red;
  logic             cond;
  logic             yo_d;

  assign red  = (MODE == 0) ? (|in_i) :
                (MODE == 1) ? (&in_i) : (^in_i);
  assign cond = en_i & red;

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      hcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      hcnt_q  <= hcnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    hcnt_d  = hcnt_q;
    if (clr_i) begin
      state_d = S_IDLE;
      qcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cond) begin
            if (QUAL_CYC == 1) begin
              state_d = S_ACTIVE;
            end else begin
              state_d = S_QUAL;
              qcnt_d  = CNT_W'(1);
            end
          end
        end
        S_QUAL: begin
          if (!cond) begin
            // A broken run earns no partial credit.
            state_d = S_IDLE;
            qcnt_d  = '0;
          end else if (qcnt_q == QUAL_LAST) begin
            state_d = S_ACTIVE;
            qcnt_d  = '0;
          end else begin
            qcnt_d = qcnt_q + CNT_W'(1);
          end
        end
        S_ACTIVE: begin
          if (!cond && !sticky_i) begin
            if (HOLD_CYC == 0) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_HOLD;
              hcnt_d  = HOLD_INIT;
            end
          end
        end
        S_HOLD: begin
          if (cond) begin
            // Retrigger straight back to ACTIVE, no requalification.
            state_d = S_ACTIVE;
            hcnt_d  = '0;
          end else if (hcnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            hcnt_d = hcnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          qcnt_d  = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // Output decode of the next state.
  always_comb begin
    yo_d = (state_d == S_ACTIVE) || (state_d == S_HOLD);
  end

  // Registered outputs; edges are detected against the current yo.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      yo     <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      yo     <= yo_d;
      rise_o <= yo_d & ~yo;
      fall_o <= ~yo_d & yo;
    end
  end

endmodule

// File: doc/eqn_reduce_qual.md
Name: eqn_reduce_qual

Overview:
- Parametrised successor to the team's registered two-input event flag.
- Reduces an N_IN-bit input vector with a selectable operator (OR/AND/XOR) into a qualified condition.
- Condition must hold for QUAL_CYC consecutive cycles before output yo asserts; yo then stays asserted for HOLD_CYC cycles after the condition drops, or indefinitely in sticky mode until cleared.
- Sits at the edge of the design as a debounced, stretched status/interrupt source; emits one-cycle rise/fall pulses for downstream event logic.

Parameters:
N_IN, 2, width of input vector (>=1)
MODE, 0, reduction operator: 0 OR, 1 AND, 2 XOR; any other value is an elaboration error
QUAL_CYC, 1, consecutive true samples required before yo asserts (>=1)
HOLD_CYC, 0, cycles yo stays high after condition drops (>=0)
CNT_W, 8, counter width; QUAL_CYC and HOLD_CYC must be <= 2^CNT_W-1 (elaboration check)

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
en_i  input  1  enable; 0 forces condition false
clr_i  input  1  synchronous clear, priority over all non-reset activity
sticky_i  input  1  1 = yo latches once ACTIVE until clr_i
in_i  input  N_IN  input vector
yo  output  1  qualified, stretched condition (registered)
rise_o  output  1  one-cycle pulse after yo 0->1
fall_o  output  1  one-cycle pulse after yo 1->0

Behaviour:
- cond = en_i & reduce(MODE, in_i), combinational, sampled each rising edge. No input synchronisers; inputs are synchronous to clk_i.
- Reset (rst_ni=0, async, immediate): state IDLE, counters 0, yo=0, rise_o=0, fall_o=0. Deassertion is synchronous to clk_i and must be externally synchronised.
- All outputs are registered. yo=1 exactly in states ACTIVE and HOLD.
- IDLE:
  - cond and QUAL_CYC==1 -> ACTIVE (latency 1 edge, matches the legacy block).
  - cond and QUAL_CYC>1 -> QUAL, qcnt=1.
  - Otherwise stay IDLE.
- QUAL:
  - !cond -> IDLE, qcnt=0 (no partial credit).
  - cond and qcnt==QUAL_CYC-1 -> ACTIVE.
  - cond otherwise -> qcnt+1.
  - yo rises at the edge where cond has been sampled true on QUAL_CYC consecutive edges.
- ACTIVE:
  - cond -> stay.
  - !cond and sticky_i -> stay.
  - !cond, HOLD_CYC==0 -> IDLE.
  - !cond, HOLD_CYC>0 -> HOLD, hcnt=HOLD_CYC-1.
- HOLD:
  - cond -> ACTIVE (retrigger, no requalification).
  - hcnt==0 -> IDLE.
  - Otherwise hcnt-1.
  - yo stays high for exactly HOLD_CYC cycles after the edge that sampled cond false.
- clr_i=1 at an edge: next state IDLE, counters 0, yo=0, regardless of cond/sticky_i. Requalification starts at the following edge.
- rise_o/fall_o: registered, = yo_next & ~yo and ~yo_next & yo. Never both high. Clear from ACTIVE/HOLD produces fall_o.
- sticky_i is sampled only in ACTIVE. Changing it in HOLD has no effect on the running countdown.
- Counters saturate-free by construction (bounded by parameters); no wrap-around is reachable.

Test Plan:
- Reset: drive rst_ni=0 mid-ACTIVE with in_i=2'b11 -> yo, rise_o, fall_o drop to 0 immediately without waiting for a clock edge; state returns to IDLE.
- Default params: in_i=2'b01 for one cycle -> yo=1 one edge later for one cycle, rise_o and fall_o each pulse once; in_i=2'b00 -> yo stays 0.
- MODE=1, N_IN=4, QUAL_CYC=3:
  - in_i=4'hF for 2 cycles, then 4'h7 -> yo stays 0.
  - in_i=4'hF for 3 cycles -> yo=1 after the 3rd edge.
- HOLD_CYC=4, cond drops at edge e -> yo high through e+3, low after e+4, fall_o pulse at e+4.
  - Retrigger at e+2 -> back to ACTIVE, yo never drops.
- sticky_i=1, MODE=2, in_i toggles to even parity -> yo stays 1.
  - clr_i pulse -> yo=0 and fall_o=1 next cycle.
  - clr_i with cond=1 in the same cycle -> yo=0 that cycle, re-asserts one edge later when QUAL_CYC=1.
- en_i=0 with in_i all ones -> yo remains 0.
  - en_i dropped while ACTIVE (HOLD_CYC=0, sticky_i=0) -> yo=0 after the next edge.
